// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req scanning ptr, ptr+1, ... mod NREQ.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    int idx;

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NREQ byte sources.
// Optional UART_ARB_LOCK_EN: req_lock keeps the current owner for its next byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [UART_DATA_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]             req_lock,
    output logic [NREQ-1:0]             ack,
    output logic [IDW-1:0]              grant_id,
    output logic                        tx_en,
    output logic                        begin_flag,
    output logic [UART_DATA_W-1:0]      tx_data,
    input  logic                        busy_flag,
    output logic                        timeout_err
);

    localparam int CNTW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [CNTW-1:0] cnt;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    logic            lock_hit;
    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  ptr_next;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req       (req),
        .ptr       (ptr),
        .winner    (pick_id),
        .any_valid (pick_any)
    );

`ifdef UART_ARB_LOCK_EN
    assign lock_hit = req_lock[grant_id] & req[grant_id];
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign lock_hit    = 1'b0;
`endif

    assign sel_id   = lock_hit ? grant_id : pick_id;
    assign ptr_next = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ack         <= '0;
            grant_id    <= '0;
            tx_en       <= 1'b0;
            begin_flag  <= 1'b0;
            tx_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_en       <= 1'b1;
            ack         <= '0;
            begin_flag  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!busy_flag && (lock_hit || pick_any)) begin
                        ack      <= NREQ'(1) << sel_id;
                        grant_id <= sel_id;
                        tx_data  <= req_data[int'(sel_id)*UART_DATA_W +: UART_DATA_W];
                        if (!lock_hit) ptr <= ptr_next;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    begin_flag <= 1'b1;
                    cnt        <= '0;
                    state      <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // A serializer that never acknowledges costs the byte, not the bus.
                    if (busy_flag) begin
                        state <= ST_WAIT_IDLE;
                    end else if (cnt == CNTW'(BUSY_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!busy_flag) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a queue-based round-robin model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int BT   = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_lock = '0;
    logic [NREQ-1:0]   ack;
    logic [IDW-1:0]    grant_id;
    logic              tx_en;
    logic              begin_flag;
    logic [7:0]        tx_data;
    logic              busy_flag = 1'b0;
    logic              timeout_err;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .ack         (ack),
        .grant_id    (grant_id),
        .tx_en       (tx_en),
        .begin_flag  (begin_flag),
        .tx_data     (tx_data),
        .busy_flag   (busy_flag),
        .timeout_err (timeout_err)
    );

    always #10 clk = ~clk;

    typedef struct { int id; logic [7:0] data; } exp_t;
    typedef logic [7:0] bq_t [$];

    exp_t sb [$];
    bq_t  rq [NREQ];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_ptr = 0;
    int   m_last = 0;
    bit   nb_mode = 1'b0;
    bit   force_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue bytes per requester and derive the grant order from the rules.
    task automatic load(input logic [NREQ-1:0] mask, input int minn, input int maxn, input int fixed);
        logic [7:0] bq [NREQ][8];
        int len [NREQ];
        int pos [NREQ];
        int total, sel, c;
        exp_t e;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            len[i] = mask[i] ? int'($urandom_range(minn, maxn)) : 0;
            pos[i] = 0;
            for (int j = 0; j < len[i]; j++) begin
                bq[i][j] = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
                rq[i].push_back(bq[i][j]);
            end
            total += len[i];
        end
        while (total > 0) begin
            sel = -1;
`ifdef UART_ARB_LOCK_EN
            if (req_lock[m_last] && pos[m_last] < len[m_last]) sel = m_last;
`endif
            if (sel < 0) begin
                for (int o = 0; o < NREQ; o++) begin
                    c = (m_ptr + o) % NREQ;
                    if (sel < 0 && pos[c] < len[c]) sel = c;
                end
                m_ptr = (sel + 1) % NREQ;
            end
            e.id = sel;
            e.data = bq[sel][pos[sel]];
            sb.push_back(e);
            pos[sel]++;
            total--;
            m_last = sel;
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += rq[i].size();
        return n;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || pending() != 0 || busy_flag) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("drain_budget", 32'(sb.size() + pending()), 0);
        repeat (BT + 6) @(negedge clk);
    endtask

    // Requesters: present the head byte; advance in the cycle after ack.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (rst_n && ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            for (int i = 0; i < NREQ; i++) begin
                req[i] = (rq[i].size() != 0);
                req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
            end
        end
    end

    // Serializer: busy rises one cycle after the strobe for a random frame length.
    initial begin
        bit busy_m = 1'b0;
        bit pend = 1'b0;
        int blen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_m = 1'b0;
                pend = 1'b0;
            end else if (pend) begin
                busy_m = 1'b1;
                pend = 1'b0;
            end else if (busy_m) begin
                blen--;
                if (blen <= 0) busy_m = 1'b0;
            end
            if (rst_n && begin_flag && !nb_mode) begin
                pend = 1'b1;
                blen = $urandom_range(2, 12);
            end
            busy_flag = busy_m | force_busy;
        end
    end

    // Monitor: pops the scoreboard on each strobe and checks protocol timing.
    initial begin
        logic            b_edge;
        logic [NREQ-1:0] prev_ack;
        logic [7:0]      held;
        bit              armed, hold;
        int              tcnt;
        exp_t            e;
        armed = 1'b0; hold = 1'b0; tcnt = 0; prev_ack = '0; held = '0;
        forever begin
            @(posedge clk);
            b_edge = busy_flag;
            @(negedge clk);
            if (!rst_n) begin
                armed = 1'b0; hold = 1'b0; prev_ack = '0;
                continue;
            end
            if (ack != '0) begin
                chk("ack_onehot", 32'($countones(ack)), 1);
                chk("ack_while_busy", 32'(b_edge), 0);
                chk("ack_matches_grant", 32'(ack[grant_id]), 1);
                hold = 1'b0;
            end
            if (prev_ack != '0 || begin_flag)
                chk("ack_to_begin", 32'(begin_flag), 32'(prev_ack != '0));
            if (hold) chk("tx_data_stable", 32'(tx_data), 32'(held));
            if (armed) tcnt++;
            if (timeout_err) begin
                chk("timeout_expected", 32'(armed), 1);
                chk("timeout_latency", 32'(tcnt), BT);
                armed = 1'b0;
            end else if (armed && tcnt > BT) begin
                chk("timeout_missing", 32'(timeout_err), 1);
                armed = 1'b0;
            end
            if (begin_flag) begin
                if (sb.size() == 0) begin
                    chk("unexpected_begin", 32'(begin_flag), 0);
                end else begin
                    e = sb.pop_front();
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    chk("tx_data", 32'(tx_data), 32'(e.data));
                end
                held = tx_data; hold = 1'b1; armed = nb_mode; tcnt = 0;
            end
            prev_ack = ack;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not end");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        // Reset state, then busy held high at release with requester 1 pending.
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_begin", 32'(begin_flag), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        load(4'b0010, 1, 1, -1);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_ack_while_busy", 32'(ack), 0);
        end
        chk("tx_en_after_reset", 32'(tx_en), 1);
        force_busy = 1'b0;
        drain(500);

        // Single requester, fixed byte.
        load(4'b0001, 1, 1, 8'hA5);
        drain(500);

        // All requesters with several bytes each.
        load(4'b1111, 2, 3, -1);
        drain(2000);

        // Serializer never answers: byte dropped, then the next request is served.
        nb_mode = 1'b1;
        load(4'b0100, 1, 1, -1);
        drain(500);
        nb_mode = 1'b0;
        load(4'b1000, 1, 1, -1);
        drain(500);

        // Randomized rounds, including timeouts and lock patterns.
        for (int r = 0; r < 8; r++) begin
            nb_mode = ($urandom_range(0, 3) == 0);
            req_lock = 4'($urandom);
            load(4'($urandom_range(1, 15)), 1, 4, -1);
            drain(3000);
        end
        nb_mode = 1'b0;
        req_lock = '0;

        // Async reset in the middle of a frame.
        load(4'b0100, 1, 1, -1);
        n = 0;
        while (!busy_flag && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen_before_reset", 32'(busy_flag), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_begin", 32'(begin_flag), 0);
        chk("midrst_tx_en", 32'(tx_en), 0);
        chk("midrst_grant_id", 32'(grant_id), 0);
        sb.delete();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        m_ptr = 0;
        m_last = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load(4'b1111, 1, 1, -1);
        drain(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
